bp_halt_ctrl: RTL and testbench
===============================

# bp_halt_ctrl

Debug halt controller that sequences the GB80 CPU against the breakpoint address register. It compares every instruction fetch against the breakpoint address and requests a CPU halt on a match. It also supports manual halt, resume and single-step from board buttons, and captures the halt PC and cause for display. It sits between the breakpoint register block, the board buttons and the CPU's halt/ack handshake.

## Interface
- HALT_ON_RESET, default 0: when 1, the controller leaves reset in STOPPING instead of RUN.
- clock, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- fetch_valid, input, 1: one-cycle strobe from the CPU marking an opcode fetch.
- fetch_addr, input, 16: PC of the opcode fetch; valid when fetch_valid=1.
- bp_addr, input, 16: breakpoint address.
- bp_enable, input, 1: breakpoint compare enable (level).
- halt_btn, input, 1: manual halt (level, already synchronised).
- run_btn, input, 1: resume (level, already synchronised).
- step_btn, input, 1: single-step (level, already synchronised).
- cpu_halted, input, 1: CPU acknowledge; high while the CPU is parked at an instruction boundary.
- cpu_halt_req, output, 1: halt request to the CPU.
- halted, output, 1: high in state HALTED.
- halt_cause, output, 2: 00 none, 01 breakpoint, 10 manual, 11 step.
- halt_pc, output, 16: fetch address captured at the halt trigger.
- bp_hit_count, output, 8: saturating count of breakpoint halts.

## Operation
- Button edges:
  - Each button has a previous-value register; an edge is btn & ~btn_prev.
  - Edges are evaluated only in the states listed below; edges in other states are discarded, not queued.
- match = fetch_valid & bp_enable & (fetch_addr == bp_addr) & ~skip.
- skip flag:
  - Set on the RUN transition out of HALTED.
  - Cleared on the first fetch_valid after it is set.
  - Purpose: resuming at the breakpoint address does not re-break immediately.
- last_pc updates on every fetch_valid.
- States:
  - RUN:
    - On match: go to STOPPING, cause=01, halt_pc=fetch_addr.
    - Else on a halt_btn edge: go to STOPPING, cause=10, halt_pc=last_pc.
    - Match wins over a same-cycle halt edge.
  - STOPPING: wait for cpu_halted=1, then go to HALTED. On that entry, if cause=01, bp_hit_count increments, saturating at 8'hFF.
  - HALTED:
    - On a run_btn edge: go to RUN and set skip.
    - Else on a step_btn edge: go to STEPPING and set skip.
    - Run wins over a same-cycle step edge.
  - STEPPING: on the first fetch_valid (the stepped instruction), go to STOPPING with cause=11 and halt_pc=fetch_addr. That fetch also clears skip.
- cpu_halt_req:
  - Registered: 1 in STOPPING and HALTED.
  - In RUN it is additionally driven high combinationally in any cycle where match=1, so the CPU stalls the matched opcode before execution.
- halt_cause and halt_pc hold their values through RUN until the next trigger overwrites them.
- bp_addr or bp_enable changing while HALTED does not affect state.

## Timing
- Reset values:
  - State = RUN (or STOPPING if HALT_ON_RESET=1).
  - cpu_halt_req=0 (1 if HALT_ON_RESET=1), halted=0, halt_cause=00, halt_pc=0000, bp_hit_count=00, skip=0, button history=0.
- Breakpoint latency:
  - cpu_halt_req rises in the match cycle (combinational) and stays high from the next edge (registered).
  - halted rises one cycle after cpu_halted is first sampled high in STOPPING.
- Button latency: a button that rises before edge N is detected at edge N; the state changes at edge N+1.
- Resume: cpu_halt_req falls at the edge that enters RUN or STEPPING.
- cpu_halted already high on entry to STOPPING: HALTED is entered on the following edge (one-cycle minimum in STOPPING).
- Reset asserted mid-handshake: state and outputs return to reset values immediately, with no wait for cpu_halted.

## Test plan
- Breakpoint hit:
  - Stimulus: bp_addr=0150, bp_enable=1, fetches 0100, 0101, 0150.
  - Required: cpu_halt_req high in the 0150 fetch cycle; after cpu_halted, halted=1, halt_cause=01, halt_pc=0150, bp_hit_count=01.
- Resume past breakpoint:
  - Stimulus: from the halted state above, pulse run_btn, then fetches 0150, 0151, then a later fetch of 0150.
  - Required: no halt on the first 0150; halt again on the later 0150, with bp_hit_count=02.
- Single step:
  - Stimulus: halted at 0150, pulse step_btn, CPU fetches 0150 and deasserts cpu_halted.
  - Required: return to STOPPING, then HALTED with halt_cause=11 and halt_pc=0150.
- Simultaneous events:
  - Stimulus: halt_btn edge in the same cycle as a 0150 match.
  - Required: halt_cause=01.
  - Stimulus: run_btn and step_btn edges in the same cycle while HALTED.
  - Required: state RUN.
- Manual halt with breakpoint disabled:
  - Stimulus: bp_enable=0, fetch 0150, then halt_btn edge after last fetch 0200.
  - Required: no break at 0150; halt_cause=10, halt_pc=0200, bp_hit_count unchanged.
- Reset mid-operation and saturation:
  - Stimulus: assert reset in STOPPING.
  - Required: cpu_halt_req=0 and halted=0 asynchronously.
  - Stimulus: force 256 breakpoint halts.
  - Required: bp_hit_count=FF.

Source files
------------

// File: rtl/bp_halt_ctrl_if.sv
// Bundle between the breakpoint register block, board buttons and CPU halt handshake.
// The slave side is the halt controller; the master side drives fetches, buttons and the acknowledge.
interface bp_halt_ctrl_if;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 8;

  logic          fetch_valid;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] bp_addr;
  logic          bp_enable;
  logic          halt_btn;
  logic          run_btn;
  logic          step_btn;
  logic          cpu_halted;
  logic          cpu_halt_req;
  logic          halted;
  logic [1:0]    halt_cause;
  logic [AW-1:0] halt_pc;
  logic [CW-1:0] bp_hit_count;

  modport slave (
    input  fetch_valid, fetch_addr, bp_addr, bp_enable,
    input  halt_btn, run_btn, step_btn, cpu_halted,
    output cpu_halt_req, halted, halt_cause, halt_pc, bp_hit_count
  );

  modport master (
    output fetch_valid, fetch_addr, bp_addr, bp_enable,
    output halt_btn, run_btn, step_btn, cpu_halted,
    input  cpu_halt_req, halted, halt_cause, halt_pc, bp_hit_count
  );
endinterface

// File: rtl/bp_halt_ctrl.sv
// Debug halt controller: breakpoint compare on opcode fetches, manual halt/run/step
// buttons, and capture of halt PC, cause and a saturating breakpoint-hit count.
module bp_halt_ctrl #(
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic           clock,
  input  logic           reset,
  bp_halt_ctrl_if.slave  bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 8;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_BP     = 2'b01;
  localparam logic [1:0] CAUSE_MANUAL = 2'b10;
  localparam logic [1:0] CAUSE_STEP   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STOPPING = 2'd1,
    ST_HALTED   = 2'd2,
    ST_STEPPING = 2'd3
  } state_t;

  localparam state_t RESET_STATE = HALT_ON_RESET ? ST_STOPPING : ST_RUN;

  state_t        state_q, state_d;
  logic          halt_prev_q, run_prev_q, step_prev_q;
  logic          halt_edge_q, run_edge_q, step_edge_q;
  logic          skip_q, skip_d;
  logic [AW-1:0] last_pc_q;
  logic [1:0]    cause_q, cause_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic          halt_req_q;
  logic          halted_q;
  logic          match_c;

  // skip masks the compare for the first fetch after leaving HALTED
  assign match_c = bus.fetch_valid & bus.bp_enable &
                   (bus.fetch_addr == bus.bp_addr) & ~skip_q;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    count_d = count_q;
    skip_d  = skip_q;
    if (bus.fetch_valid) skip_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (match_c) begin
          state_d = ST_STOPPING;
          cause_d = CAUSE_BP;
          pc_d    = bus.fetch_addr;
        end else if (halt_edge_q) begin
          state_d = ST_STOPPING;
          cause_d = CAUSE_MANUAL;
          pc_d    = last_pc_q;
        end
      end
      ST_STOPPING: begin
        if (bus.cpu_halted) begin
          state_d = ST_HALTED;
          if (cause_q == CAUSE_BP && count_q != '1) count_d = count_q + CW'(1);
        end
      end
      ST_HALTED: begin
        if (run_edge_q) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (step_edge_q) begin
          state_d = ST_STEPPING;
          skip_d  = 1'b1;
        end
      end
      ST_STEPPING: begin
        if (bus.fetch_valid) begin
          state_d = ST_STOPPING;
          cause_d = CAUSE_STEP;
          pc_d    = bus.fetch_addr;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Button edges are registered, so the state reacts one edge after detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halt_prev_q  <= 1'b0;
      run_prev_q   <= 1'b0;
      step_prev_q  <= 1'b0;
      halt_edge_q  <= 1'b0;
      run_edge_q   <= 1'b0;
      step_edge_q  <= 1'b0;
      skip_q       <= 1'b0;
      last_pc_q    <= '0;
      cause_q      <= CAUSE_NONE;
      pc_q         <= '0;
      count_q      <= '0;
      halt_req_q   <= HALT_ON_RESET;
      halted_q     <= 1'b0;
    end else begin
      halt_prev_q  <= bus.halt_btn;
      run_prev_q   <= bus.run_btn;
      step_prev_q  <= bus.step_btn;
      halt_edge_q  <= bus.halt_btn & ~halt_prev_q;
      run_edge_q   <= bus.run_btn  & ~run_prev_q;
      step_edge_q  <= bus.step_btn & ~step_prev_q;
      skip_q       <= skip_d;
      if (bus.fetch_valid) last_pc_q <= bus.fetch_addr;
      cause_q      <= cause_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      halt_req_q   <= (state_d == ST_STOPPING) || (state_d == ST_HALTED);
      halted_q     <= (state_d == ST_HALTED);
    end
  end

  // Combinational term stalls the matched opcode before it executes
  assign bus.cpu_halt_req = halt_req_q | (~reset & (state_q == ST_RUN) & match_c);
  assign bus.halted       = halted_q;
  assign bus.halt_cause   = cause_q;
  assign bus.halt_pc      = pc_q;
  assign bus.bp_hit_count = count_q;
endmodule

// File: tb/tb_bp_halt_ctrl.sv
// Self-checking bench for bp_halt_ctrl: directed test-plan scenarios, then random
// stimulus compared every cycle against a behavioural model of the halt sequencing.
module tb_bp_halt_ctrl;
  logic clock = 1'b0;
  logic reset;

  bp_halt_ctrl_if bif ();
  bp_halt_ctrl_if hif ();

  bp_halt_ctrl #(.HALT_ON_RESET(1'b0)) dut   (.clock(clock), .reset(reset), .bus(bif));
  bp_halt_ctrl #(.HALT_ON_RESET(1'b1)) dut_h (.clock(clock), .reset(reset), .bus(hif));

  assign hif.fetch_valid = bif.fetch_valid;
  assign hif.fetch_addr  = bif.fetch_addr;
  assign hif.bp_addr     = bif.bp_addr;
  assign hif.bp_enable   = bif.bp_enable;
  assign hif.halt_btn    = bif.halt_btn;
  assign hif.run_btn     = bif.run_btn;
  assign hif.step_btn    = bif.step_btn;
  assign hif.cpu_halted  = bif.cpu_halted;

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model
  localparam int M_RUN = 0, M_STOP = 1, M_HALT = 2, M_STEP = 3;
  int         m_mode;
  int         m_cause;
  int         m_pc;
  int         m_cnt;
  int         m_last;
  bit         m_skip;
  bit         m_hp, m_rp, m_sp;
  bit         m_he, m_re, m_se;

  task automatic model_reset();
    m_mode = M_RUN; m_cause = 0; m_pc = 0; m_cnt = 0; m_last = 0; m_skip = 0;
    m_hp = 0; m_rp = 0; m_sp = 0; m_he = 0; m_re = 0; m_se = 0;
  endtask

  function automatic bit m_match();
    return bif.fetch_valid && bif.bp_enable && (bif.fetch_addr == bif.bp_addr) && !m_skip;
  endfunction

  function automatic bit exp_req();
    if (reset) return 1'b0;
    return (m_mode == M_STOP) || (m_mode == M_HALT) || (m_mode == M_RUN && m_match());
  endfunction

  task automatic model_step();
    int nmode;
    bit match;
    if (reset) begin model_reset(); return; end
    match = m_match();
    nmode = m_mode;
    if (m_mode == M_RUN) begin
      if (match) begin nmode = M_STOP; m_cause = 1; m_pc = int'(bif.fetch_addr); end
      else if (m_he) begin nmode = M_STOP; m_cause = 2; m_pc = m_last; end
    end else if (m_mode == M_STOP) begin
      if (bif.cpu_halted) begin
        nmode = M_HALT;
        if (m_cause == 1) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end else if (m_mode == M_HALT) begin
      if (m_re) nmode = M_RUN;
      else if (m_se) nmode = M_STEP;
    end else begin
      if (bif.fetch_valid) begin nmode = M_STOP; m_cause = 3; m_pc = int'(bif.fetch_addr); end
    end
    if (m_mode == M_HALT && nmode != M_HALT) m_skip = 1;
    else if (bif.fetch_valid) m_skip = 0;
    if (bif.fetch_valid) m_last = int'(bif.fetch_addr);
    m_he = bif.halt_btn && !m_hp; m_hp = bif.halt_btn;
    m_re = bif.run_btn  && !m_rp; m_rp = bif.run_btn;
    m_se = bif.step_btn && !m_sp; m_sp = bif.step_btn;
    m_mode = nmode;
  endtask

  // Called in the low phase with inputs set; compares, then advances one clock
  task automatic tick();
    #1;
    if (reset) model_reset();
    check("req",    32'(bif.cpu_halt_req), 32'(exp_req()));
    check("halted", 32'(bif.halted),       32'(m_mode == M_HALT));
    check("cause",  32'(bif.halt_cause),   32'(m_cause));
    check("pc",     32'(bif.halt_pc),      32'(m_pc));
    check("count",  32'(bif.bp_hit_count), 32'(m_cnt));
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic fetch(input logic [15:0] a);
    bif.fetch_valid = 1'b1; bif.fetch_addr = a;
    tick();
    bif.fetch_valid = 1'b0;
  endtask

  task automatic pulse_run();
    bif.run_btn = 1'b1; tick();
    bif.run_btn = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b1;
    bif.fetch_valid = 0; bif.fetch_addr = '0; bif.bp_addr = 16'h0150; bif.bp_enable = 1'b1;
    bif.halt_btn = 0; bif.run_btn = 0; bif.step_btn = 0; bif.cpu_halted = 0;
    model_reset();
    @(negedge clock);
    tick();
    #1;
    check("rst_req",    32'(bif.cpu_halt_req), 32'd0);
    check("rst_halted", 32'(bif.halted),       32'd0);
    check("rst_count",  32'(bif.bp_hit_count), 32'd0);
    check("hor_req",    32'(hif.cpu_halt_req), 32'd1);
    check("hor_halted", 32'(hif.halted),       32'd0);
    reset = 1'b0;
    tick(); tick();
    check("hor_stays_req", 32'(hif.cpu_halt_req), 32'd1);

    // Breakpoint hit
    fetch(16'h0100);
    fetch(16'h0101);
    bif.fetch_valid = 1'b1; bif.fetch_addr = 16'h0150; #1;
    check("bp_req_comb", 32'(bif.cpu_halt_req), 32'd1);
    tick(); bif.fetch_valid = 1'b0;
    tick();
    bif.cpu_halted = 1'b1; tick(); #1;
    check("bp_halted", 32'(bif.halted),       32'd1);
    check("bp_cause",  32'(bif.halt_cause),   32'd1);
    check("bp_pc",     32'(bif.halt_pc),      32'h0150);
    check("bp_count",  32'(bif.bp_hit_count), 32'd1);

    // Resume past breakpoint
    pulse_run();
    bif.cpu_halted = 1'b0;
    bif.fetch_valid = 1'b1; bif.fetch_addr = 16'h0150; #1;
    check("skip_no_req", 32'(bif.cpu_halt_req), 32'd0);
    tick();
    fetch(16'h0151);
    fetch(16'h0100);
    bif.fetch_valid = 1'b1; bif.fetch_addr = 16'h0150; #1;
    check("rebreak_req", 32'(bif.cpu_halt_req), 32'd1);
    tick(); bif.fetch_valid = 1'b0;
    bif.cpu_halted = 1'b1; tick(); #1;
    check("rebreak_count", 32'(bif.bp_hit_count), 32'd2);

    // Single step
    bif.step_btn = 1'b1; tick();
    bif.step_btn = 1'b0; tick(); #1;
    check("step_req", 32'(bif.cpu_halt_req), 32'd0);
    bif.cpu_halted = 1'b0;
    fetch(16'h0150);
    bif.cpu_halted = 1'b1; tick(); #1;
    check("step_halted", 32'(bif.halted),     32'd1);
    check("step_cause",  32'(bif.halt_cause), 32'd3);
    check("step_pc",     32'(bif.halt_pc),    32'h0150);

    // Run and step edges together: run wins
    bif.run_btn = 1'b1; bif.step_btn = 1'b1; tick();
    bif.run_btn = 1'b0; bif.step_btn = 1'b0; tick(); #1;
    check("both_halted", 32'(bif.halted),       32'd0);
    check("both_req",    32'(bif.cpu_halt_req), 32'd0);
    bif.cpu_halted = 1'b0;
    fetch(16'h0151);
    // Halt edge coincides with a breakpoint match: breakpoint wins
    bif.halt_btn = 1'b1; tick();
    fetch(16'h0150);
    bif.halt_btn = 1'b0; bif.cpu_halted = 1'b1; tick(); #1;
    check("race_cause", 32'(bif.halt_cause),   32'd1);
    check("race_count", 32'(bif.bp_hit_count), 32'd3);

    // Manual halt with breakpoint disabled
    pulse_run();
    bif.cpu_halted = 1'b0; bif.bp_enable = 1'b0;
    bif.fetch_valid = 1'b1; bif.fetch_addr = 16'h0150; #1;
    check("dis_no_req", 32'(bif.cpu_halt_req), 32'd0);
    tick(); bif.fetch_valid = 1'b0;
    fetch(16'h0200);
    bif.halt_btn = 1'b1; tick();
    bif.halt_btn = 1'b0; tick(); #1;
    check("man_cause", 32'(bif.halt_cause), 32'd2);
    check("man_pc",    32'(bif.halt_pc),    32'h0200);
    bif.cpu_halted = 1'b1; tick(); #1;
    check("man_count", 32'(bif.bp_hit_count), 32'd3);

    // Reset while stopping
    pulse_run();
    bif.cpu_halted = 1'b0; bif.bp_enable = 1'b1;
    fetch(16'h0151);
    fetch(16'h0150);
    tick(); #1;
    check("stop_req", 32'(bif.cpu_halt_req), 32'd1);
    reset = 1'b1; #1;
    check("arst_req",    32'(bif.cpu_halt_req), 32'd0);
    check("arst_halted", 32'(bif.halted),       32'd0);
    check("arst_count",  32'(bif.bp_hit_count), 32'd0);
    model_reset();
    tick();
    reset = 1'b0;
    tick();

    // Saturation of the breakpoint counter
    for (int i = 0; i < 260; i++) begin
      fetch(16'h0150);
      bif.cpu_halted = 1'b1; tick();
      pulse_run();
      bif.cpu_halted = 1'b0;
      fetch(16'h0151);
    end
    #1;
    check("sat_count", 32'(bif.bp_hit_count), 32'hFF);

    // Random stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset = ($urandom_range(0, 399) == 0);
      bif.fetch_valid = $urandom_range(0, 1) == 1;
      r = int'($urandom_range(0, 3));
      case (r)
        0: bif.fetch_addr = 16'h0150;
        1: bif.fetch_addr = 16'h0151;
        2: bif.fetch_addr = bif.bp_addr;
        default: bif.fetch_addr = 16'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) bif.bp_addr = ($urandom_range(0, 1) == 1) ? 16'h0150 : 16'($urandom);
      if ($urandom_range(0, 19) == 0) bif.bp_enable  = ~bif.bp_enable;
      if ($urandom_range(0, 5)  == 0) bif.halt_btn   = ~bif.halt_btn;
      if ($urandom_range(0, 5)  == 0) bif.run_btn    = ~bif.run_btn;
      if ($urandom_range(0, 5)  == 0) bif.step_btn   = ~bif.step_btn;
      if ($urandom_range(0, 3)  == 0) bif.cpu_halted = ~bif.cpu_halted;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
